// File: rtl/wbu_multi.sv
// wbu_multi: multi-issue write-back stage. Latches a bundle of LANES results and
// retires their register-file writes through WPORTS ports in lane order.
module wbu_multi #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int PCW    = 32,
  localparam int LW    = 1 + AW + DW + PCW,
  localparam int FW    = 1 + AW + DW
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  wb_allowin,
  input  logic                  mem_to_wb_valid,
  input  logic [LANES*LW-1:0]   mem_to_wb_zip,
  input  logic                  wb_flush,
  output logic [WPORTS-1:0]     rf_we,
  output logic [WPORTS*AW-1:0]  rf_waddr,
  output logic [WPORTS*DW-1:0]  rf_wdata,
  output logic [LANES*FW-1:0]   wb_fwd_zip,
  output logic [WPORTS*PCW-1:0] debug_wb_pc,
  output logic [WPORTS*4-1:0]   debug_wb_rf_we,
  output logic [WPORTS*AW-1:0]  debug_wb_rf_wnum,
  output logic [WPORTS*DW-1:0]  debug_wb_rf_wdata
);

  logic             wb_valid_q, wb_valid_d;
  logic [LANES-1:0] pend_q, pend_d;
  logic [AW-1:0]    waddr_q [LANES];
  logic [AW-1:0]    waddr_d [LANES];
  logic [DW-1:0]    wdata_q [LANES];
  logic [DW-1:0]    wdata_d [LANES];
  logic [PCW-1:0]   pc_q    [LANES];
  logic [PCW-1:0]   pc_d    [LANES];

  logic [LANES-1:0] in_we;
  logic [AW-1:0]    in_waddr [LANES];
  logic [DW-1:0]    in_wdata [LANES];
  logic [PCW-1:0]   in_pc    [LANES];

  logic [WPORTS-1:0] sel_vld;
  logic [WPORTS-1:0] kill;
  logic [LANES-1:0]  sel_mask;
  logic [AW-1:0]     sel_addr [WPORTS];
  logic [DW-1:0]     sel_data [WPORTS];
  logic [PCW-1:0]    sel_pc   [WPORTS];
  int                pend_cnt;

  logic ready_go;
  logic accept;

  // Lane record layout is {we, waddr, wdata, pc} with pc in the LSBs.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_we[i]    = mem_to_wb_zip[i*LW + LW - 1];
      in_waddr[i] = mem_to_wb_zip[i*LW + PCW + DW +: AW];
      in_wdata[i] = mem_to_wb_zip[i*LW + PCW +: DW];
      in_pc[i]    = mem_to_wb_zip[i*LW +: PCW];
    end
  end

  // Port p takes the (p+1)-th lowest pending lane; pend_cnt ends as popcount(pend).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_vld  = '0;
    sel_mask = '0;
    pend_cnt = 0;
    for (int p = 0; p < WPORTS; p++) begin
      sel_addr[p] = '0;
      sel_data[p] = '0;
      sel_pc[p]   = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (pend_q[i]) begin
        for (int p = 0; p < WPORTS; p++) begin
          if (pend_cnt == p) begin
            sel_vld[p]  = 1'b1;
            sel_mask[i] = 1'b1;
            sel_addr[p] = waddr_q[i];
            sel_data[p] = wdata_q[i];
            sel_pc[p]   = pc_q[i];
          end
        end
        pend_cnt = pend_cnt + 1;
      end
    end
  end

  // A lower port loses to any higher port writing the same register this cycle.
  always_comb begin
    kill = '0;
    for (int p = 0; p < WPORTS; p++) begin
      for (int q = p + 1; q < WPORTS; q++) begin
        if (sel_vld[p] && sel_vld[q] && (sel_addr[p] == sel_addr[q])) kill[p] = 1'b1;
      end
    end
  end

  assign ready_go   = (pend_cnt <= WPORTS);
  assign wb_allowin = ~wb_valid_q | ready_go;
  assign accept     = mem_to_wb_valid & wb_allowin & ~wb_flush;

  always_comb begin
    rf_we             = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int p = 0; p < WPORTS; p++) begin
      rf_we[p] = wb_valid_q & sel_vld[p] & ~kill[p];
      if (rf_we[p]) begin
        rf_waddr[p*AW +: AW]          = sel_addr[p];
        rf_wdata[p*DW +: DW]          = sel_data[p];
        debug_wb_pc[p*PCW +: PCW]     = sel_pc[p];
        debug_wb_rf_we[p*4 +: 4]      = 4'hf;
        debug_wb_rf_wnum[p*AW +: AW]  = sel_addr[p];
        debug_wb_rf_wdata[p*DW +: DW] = sel_data[p];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      wb_fwd_zip[i*FW +: FW] = wb_valid_q ? {pend_q[i], waddr_q[i], wdata_q[i]} : '0;
    end
  end

  // Flush has the last word: it drops the held bundle and any incoming one.
  always_comb begin
    wb_valid_d = wb_valid_q;
    pend_d     = pend_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    if (wb_valid_q) pend_d = pend_q & ~sel_mask;
    if (wb_valid_q && ready_go) wb_valid_d = 1'b0;
    if (accept) begin
      wb_valid_d = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        pend_d[i]  = in_we[i] & (|in_waddr[i]);
        waddr_d[i] = in_waddr[i];
        wdata_d[i] = in_wdata[i];
        pc_d[i]    = in_pc[i];
      end
    end
    if (wb_flush) begin
      wb_valid_d = 1'b0;
      pend_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      pend_q     <= '0;
      // NOTE: the lane record arrays are small flop banks, not RAM, so they reset element by element.
      for (int i = 0; i < LANES; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      pend_q     <= pend_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_wbu_multi.sv
// Scoreboard bench for wbu_multi: one instance with a single write port and one
// with two ports, each checked by its own write monitor.
module tb_wbu_multi;
  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int PCW   = 32;
  localparam int LW    = 1 + AW + DW + PCW;
  localparam int FW    = 1 + AW + DW;

  typedef struct {
    int             cyc;
    int             port;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [PCW-1:0] pc;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  wr_t  q1[$];
  wr_t  q2[$];
  wr_t  m1, m2;

  // Instance 1: LANES=2, WPORTS=1
  logic                  allow_1, valid_1, flush_1;
  logic [LANES*LW-1:0]   zip_1;
  logic [0:0]            we_1;
  logic [AW-1:0]         waddr_1, dnum_1;
  logic [DW-1:0]         wdata_1, ddata_1;
  logic [LANES*FW-1:0]   fwd_1;
  logic [PCW-1:0]        dpc_1;
  logic [3:0]            dwe_1;

  // Instance 2: LANES=2, WPORTS=2
  logic                  allow_2, valid_2, flush_2;
  logic [LANES*LW-1:0]   zip_2;
  logic [1:0]            we_2;
  logic [2*AW-1:0]       waddr_2, dnum_2;
  logic [2*DW-1:0]       wdata_2, ddata_2;
  logic [LANES*FW-1:0]   fwd_2;
  logic [2*PCW-1:0]      dpc_2;
  logic [7:0]            dwe_2;

  wbu_multi #(.LANES(LANES), .WPORTS(1), .DW(DW), .AW(AW), .PCW(PCW)) dut1 (
    .clk(clk), .reset(reset), .wb_allowin(allow_1), .mem_to_wb_valid(valid_1),
    .mem_to_wb_zip(zip_1), .wb_flush(flush_1), .rf_we(we_1), .rf_waddr(waddr_1),
    .rf_wdata(wdata_1), .wb_fwd_zip(fwd_1), .debug_wb_pc(dpc_1),
    .debug_wb_rf_we(dwe_1), .debug_wb_rf_wnum(dnum_1), .debug_wb_rf_wdata(ddata_1)
  );

  wbu_multi #(.LANES(LANES), .WPORTS(2), .DW(DW), .AW(AW), .PCW(PCW)) dut2 (
    .clk(clk), .reset(reset), .wb_allowin(allow_2), .mem_to_wb_valid(valid_2),
    .mem_to_wb_zip(zip_2), .wb_flush(flush_2), .rf_we(we_2), .rf_waddr(waddr_2),
    .rf_wdata(wdata_2), .wb_fwd_zip(fwd_2), .debug_wb_pc(dpc_2),
    .debug_wb_rf_we(dwe_2), .debug_wb_rf_wnum(dnum_2), .debug_wb_rf_wdata(ddata_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rec(logic we, logic [AW-1:0] a, logic [DW-1:0] d,
                                        logic [PCW-1:0] pc);
    return {we, a, d, pc};
  endfunction

  function automatic logic [1:0] pend_of(logic [LANES*FW-1:0] f);
    return {f[2*FW-1], f[FW-1]};
  endfunction

  function automatic logic [191:0] pk(int c, int p, logic [AW-1:0] a, logic [DW-1:0] d,
                                      logic [PCW-1:0] pc, logic [AW-1:0] wn,
                                      logic [DW-1:0] wd, logic [3:0] dw);
    return {c, p, a, d, pc, wn, wd, dw};
  endfunction

  // Expect a write on instance `which`, port `port`, dc cycles after the current one.
  task automatic expw(int which, int dc, int port, logic [AW-1:0] a, logic [DW-1:0] d,
                      logic [PCW-1:0] pc);
    wr_t e;
    e.cyc = cyc + dc; e.port = port; e.addr = a; e.data = d; e.pc = pc;
    if (which == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && we_1[0]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_write: got r%0d=%h at cycle %0d, expected no write",
                 waddr_1, wdata_1, cyc);
      end else begin
        m1 = q1.pop_front();
        check("d1_write", pk(cyc, 0, waddr_1, wdata_1, dpc_1, dnum_1, ddata_1, dwe_1),
              pk(m1.cyc, m1.port, m1.addr, m1.data, m1.pc, m1.addr, m1.data, 4'hf));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (we_2[p]) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL d2_unexpected_write: got port %0d r%0d at cycle %0d, expected no write",
                     p, waddr_2[p*AW +: AW], cyc);
          end else begin
            m2 = q2.pop_front();
            check("d2_write", pk(cyc, p, waddr_2[p*AW +: AW], wdata_2[p*DW +: DW],
                                 dpc_2[p*PCW +: PCW], dnum_2[p*AW +: AW],
                                 ddata_2[p*DW +: DW], dwe_2[p*4 +: 4]),
                  pk(m2.cyc, m2.port, m2.addr, m2.data, m2.pc, m2.addr, m2.data, 4'hf));
          end
        end
      end
    end
  end

  initial begin
    valid_1 = 1'b0; flush_1 = 1'b0; zip_1 = '0;
    valid_2 = 1'b0; flush_2 = 1'b0; zip_2 = '0;
    #2;
    check("reset_allowin", {allow_1, allow_2}, 2'b11);
    check("reset_we", {we_1, we_2, dwe_1, dwe_2}, '0);
    check("reset_fwd", {fwd_1, fwd_2}, '0);
    check("reset_dbg", {dpc_1, dpc_2, waddr_1, waddr_2, wdata_1, wdata_2}, '0);
    step();
    step();
    reset = 1'b0;

    // Two ports, both lanes write r5: only the higher lane on port 1 retires.
    valid_2 = 1'b1;
    zip_2 = {rec(1'b1, 5'd5, 32'hb, 32'h100), rec(1'b1, 5'd5, 32'ha, 32'h0fc)};
    expw(2, 1, 1, 5'd5, 32'hb, 32'h100);
    step();
    check("d2_conflict_we", we_2, 2'b10);
    check("d2_conflict_allowin", allow_2, 1'b1);
    zip_2 = {rec(1'b1, 5'd7, 32'h7, 32'h204), rec(1'b1, 5'd6, 32'h6, 32'h200)};
    expw(2, 1, 0, 5'd6, 32'h6, 32'h200);
    expw(2, 1, 1, 5'd7, 32'h7, 32'h204);
    step();
    check("d2_dual_we", we_2, 2'b11);
    zip_2 = {rec(1'b1, 5'd9, 32'h9, 32'h304), rec(1'b1, 5'd0, 32'hdead, 32'h300)};
    expw(2, 1, 0, 5'd9, 32'h9, 32'h304);
    step();
    check("d2_r0_skip_we", we_2, 2'b01);
    valid_2 = 1'b0;
    step();
    check("d2_idle", {we_2, allow_2}, 3'b001);

    // One port, two writes: two-cycle drain.
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd4, 32'h22, 32'h1c000004), rec(1'b1, 5'd3, 32'h11, 32'h1c000000)};
    expw(1, 1, 0, 5'd3, 32'h11, 32'h1c000000);
    expw(1, 2, 0, 5'd4, 32'h22, 32'h1c000004);
    step();
    valid_1 = 1'b0;
    check("drain_c1_allowin", allow_1, 1'b0);
    check("drain_c1_pend", pend_of(fwd_1), 2'b11);
    step();
    check("drain_c2_allowin", allow_1, 1'b1);
    check("drain_c2_pend", pend_of(fwd_1), 2'b10);

    // Accepted on the last drain edge: no retiring writes, one cycle.
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd0, 32'h55, 32'h1c000010), rec(1'b0, 5'd7, 32'h77, 32'h1c00000c)};
    step();
    check("noop_allowin", allow_1, 1'b1);
    check("noop_we_pend", {we_1, pend_of(fwd_1)}, 3'b000);

    // Stream of single-write bundles with valid held high.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        zip_1 = {rec(1'b0, 5'd1, 32'h0, 32'h0), rec(1'b1, 5'(10 + k), 32'(32'ha00 + k), 32'(32'h2000 + 8*k))};
      else
        zip_1 = {rec(1'b1, 5'(10 + k), 32'(32'ha00 + k), 32'(32'h2004 + 8*k)), rec(1'b1, 5'd0, 32'h1, 32'h0)};
      expw(1, 1, 0, 5'(10 + k), 32'(32'ha00 + k), (k % 2 == 0) ? 32'(32'h2000 + 8*k) : 32'(32'h2004 + 8*k));
      step();
      check("stream_allowin", allow_1, 1'b1);
    end
    valid_1 = 1'b0;
    step();
    check("stream_end_we", we_1, 1'b0);

    // Flush in the last drain cycle together with a new bundle.
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd21, 32'h21, 32'h3004), rec(1'b1, 5'd20, 32'h20, 32'h3000)};
    expw(1, 1, 0, 5'd20, 32'h20, 32'h3000);
    expw(1, 2, 0, 5'd21, 32'h21, 32'h3004);
    step();
    valid_1 = 1'b0;
    step();
    flush_1 = 1'b1;
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd23, 32'h23, 32'h3104), rec(1'b1, 5'd22, 32'h22, 32'h3100)};
    check("flush_cycle_pend", pend_of(fwd_1), 2'b10);
    step();
    flush_1 = 1'b0;
    valid_1 = 1'b0;
    check("flush_after", {we_1, pend_of(fwd_1), allow_1}, 4'b0001);
    step();
    check("flush_dropped_we", we_1, 1'b0);

    // Flush with a write still left after the current one: that write is lost.
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd25, 32'h25, 32'h4004), rec(1'b1, 5'd24, 32'h24, 32'h4000)};
    expw(1, 1, 0, 5'd24, 32'h24, 32'h4000);
    step();
    valid_1 = 1'b0;
    flush_1 = 1'b1;
    step();
    flush_1 = 1'b0;
    check("flush_mid_after", {we_1, pend_of(fwd_1), allow_1}, 4'b0001);

    // Asynchronous reset mid-drain.
    valid_1 = 1'b1;
    zip_1 = {rec(1'b1, 5'd27, 32'h27, 32'h5004), rec(1'b1, 5'd26, 32'h26, 32'h5000)};
    expw(1, 1, 0, 5'd26, 32'h26, 32'h5000);
    step();
    valid_1 = 1'b0;
    check("prereset_pend", pend_of(fwd_1), 2'b11);
    #5;
    reset = 1'b1;
    #1;
    check("async_reset_outs", {we_1, dwe_1, pend_of(fwd_1), allow_1}, 8'b0000_0001);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_reset_we", {we_1, pend_of(fwd_1)}, 3'b000);
    step();

    check("d1_queue_empty", q1.size(), 0);
    check("d2_queue_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
